// File: rtl/seg_scroller_param.sv
`default_nettype none
// ============================================================================
// Module   : seg_scroller_param
// Purpose  : Scrolling-message engine for the DE2 seven-segment bank.
//            A circular tape (message characters followed by GAP blanks)
//            is shown across NUM_DIGITS digits and advanced one character
//            every TICK_DIV clocks, left or right, with runtime pause.
// Ports    : CLOCK_50     system clock (50 MHz)
//            SW[0]        synchronous active-high reset (not synchronised)
//            SW[1]        direction, 0 = text moves left, 1 = text moves right
//            SW[2]        pause
//            HEX0..HEX7   registered active-low segment outputs
//                         (HEX(NUM_DIGITS-1) leftmost active, HEX0 rightmost)
// Revision : 1.0  initial release
// ============================================================================
module seg_scroller_param #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 4,
  parameter logic [7*MSG_LEN-1:0] MSG =
    {7'b0001110, 7'b0001100, 7'b0000010, 7'b0001000},
  parameter int GAP        = 4,
  parameter int TICK_DIV   = 50000000
) (
  input  logic       CLOCK_50,
  input  logic [2:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [6:0] HEX6,
  output logic [6:0] HEX7
);

  localparam int TAPE_LEN = MSG_LEN + GAP;
  localparam int POS_W    = (TAPE_LEN > 1) ? $clog2(TAPE_LEN) : 1;
  localparam int CNT_W    = $clog2(TICK_DIV);

  localparam logic [6:0]       BLANK    = 7'b1111111;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(TAPE_LEN - 1);
  localparam logic [POS_W:0]   LEN_EXT  = (POS_W+1)'(TAPE_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  localparam logic [1:0] ST_START = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic clk;
  logic rst;
  assign clk = CLOCK_50;
  assign rst = SW[0];

  // Tape contents: message characters (character 0 in the MSB slice)
  // followed by GAP blank characters.
  logic [6:0] tape [TAPE_LEN];

  for (genvar i = 0; i < TAPE_LEN; i++) begin : g_tape
    if (i < MSG_LEN) begin : g_msg
      assign tape[i] = MSG[7*(MSG_LEN-1-i) +: 7];
    end else begin : g_gap
      assign tape[i] = BLANK;
    end
  end

  // State
  logic [1:0]       state_q,    state_d;
  logic             from_run_q, from_run_d;  // HOLD origin: 1 = RUN, 0 = START
  logic [POS_W-1:0] pos_q,      pos_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             dir_s1_q,   dir_s1_d;
  logic             dir_s2_q,   dir_s2_d;
  logic             pause_s1_q, pause_s1_d;
  logic             pause_s2_q, pause_s2_d;
  logic [6:0]       hex_q [8];
  logic [6:0]       hex_d [8];

  logic             tick;
  logic [1:0]       active_state;
  logic             show_d;
  logic [POS_W:0]   idx;

  // Two-flop synchronisers for direction and pause.
  always_comb begin
    dir_s1_d   = SW[1];
    dir_s2_d   = dir_s1_q;
    pause_s1_d = SW[2];
    pause_s2_d = pause_s1_q;
  end

  // Control: tick generation, state and position update.
  always_comb begin
    state_d      = state_q;
    from_run_d   = from_run_q;
    pos_d        = pos_q;
    cnt_d        = cnt_q;
    tick         = (cnt_q == CNT_LAST) && !pause_s2_q;

    // While holding, behave as the state that was paused.
    case (state_q)
      ST_RUN:  active_state = ST_RUN;
      ST_HOLD: active_state = from_run_q ? ST_RUN : ST_START;
      default: active_state = ST_START;
    endcase

    if (pause_s2_q) begin
      // Pause wins over a coincident tick: counter and position frozen.
      if (state_q != ST_HOLD) begin
        from_run_d = (active_state == ST_RUN);
        state_d    = ST_HOLD;
      end
    end else begin
      state_d = active_state;
      cnt_d   = tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        if (active_state == ST_START) begin
          state_d = ST_RUN;
          pos_d   = '0;
        end else if (dir_s2_q) begin
          pos_d = (pos_q == '0) ? POS_LAST : pos_q - 1'b1;
        end else begin
          pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
        end
      end
    end
  end

  // Display is computed from next-state values so it changes on the same
  // edge as the position.
  always_comb begin
    show_d = (state_d == ST_RUN) || ((state_d == ST_HOLD) && from_run_d);
    idx    = '0;
    for (int k = 0; k < 8; k++) begin
      hex_d[k] = BLANK;
      if ((k < NUM_DIGITS) && show_d) begin
        // Per-digit offset is a constant; one conditional subtract wraps it.
        idx = {1'b0, pos_d} + (POS_W+1)'((NUM_DIGITS - 1 - k) % TAPE_LEN);
        if (idx >= LEN_EXT) begin
          idx = idx - LEN_EXT;
        end
        hex_d[k] = tape[idx[POS_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_START;
      from_run_q <= 1'b0;
      pos_q      <= '0;
      cnt_q      <= '0;
      dir_s1_q   <= 1'b0;
      dir_s2_q   <= 1'b0;
      pause_s1_q <= 1'b0;
      pause_s2_q <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        hex_q[k] <= BLANK;
      end
    end else begin
      state_q    <= state_d;
      from_run_q <= from_run_d;
      pos_q      <= pos_d;
      cnt_q      <= cnt_d;
      dir_s1_q   <= dir_s1_d;
      dir_s2_q   <= dir_s2_d;
      pause_s1_q <= pause_s1_d;
      pause_s2_q <= pause_s2_d;
      hex_q      <= hex_d;
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign HEX6 = hex_q[6];
  assign HEX7 = hex_q[7];

endmodule
`default_nettype wire
